// File: rtl/imem_program_loader_pkg.sv
// Shared encoding constants for the program loader and the control decoder:
// operation classes, MIPS opcode/funct fields, word builders and loader FSM states.
package imem_program_loader_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_SLT  = 5'd4,
    OP_NOR  = 5'd5,
    OP_SLL  = 5'd6,
    OP_SRL  = 5'd7,
    OP_LW   = 5'd8,
    OP_SW   = 5'd9,
    OP_ADDI = 5'd10,
    OP_ANDI = 5'd11,
    OP_ORI  = 5'd12,
    OP_SLTI = 5'd13,
    OP_BEQ  = 5'd14,
    OP_BNE  = 5'd15,
    OP_J    = 5'd16
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_FULL = 2'd3
  } state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opcode, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opcode, rs, rt, imm};
  endfunction

endpackage

// File: rtl/imem_program_loader_instr_pack.sv
// instr_pack: combinational encoder from operation class plus fields to a
// 32-bit MIPS word; unknown classes yield a NOP and raise the illegal flag.
module instr_pack
  import imem_program_loader_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the encoding for the operation class; shifts ignore rs, others ignore shamt.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (op_e'(op))
      OP_ADD:  word = r_word(rs, rt, rd, 5'd0, FUNCT_ADD);
      OP_SUB:  word = r_word(rs, rt, rd, 5'd0, FUNCT_SUB);
      OP_AND:  word = r_word(rs, rt, rd, 5'd0, FUNCT_AND);
      OP_OR:   word = r_word(rs, rt, rd, 5'd0, FUNCT_OR);
      OP_SLT:  word = r_word(rs, rt, rd, 5'd0, FUNCT_SLT);
      OP_NOR:  word = r_word(rs, rt, rd, 5'd0, FUNCT_NOR);
      OP_SLL:  word = r_word(5'd0, rt, rd, shamt, FUNCT_SLL);
      OP_SRL:  word = r_word(5'd0, rt, rd, shamt, FUNCT_SRL);
      OP_LW:   word = i_word(OPC_LW, rs, rt, imm);
      OP_SW:   word = i_word(OPC_SW, rs, rt, imm);
      OP_ADDI: word = i_word(OPC_ADDI, rs, rt, imm);
      OP_ANDI: word = i_word(OPC_ANDI, rs, rt, imm);
      OP_ORI:  word = i_word(OPC_ORI, rs, rt, imm);
      OP_SLTI: word = i_word(OPC_SLTI, rs, rt, imm);
      OP_BEQ:  word = i_word(OPC_BEQ, rs, rt, imm);
      OP_BNE:  word = i_word(OPC_BNE, rs, rt, imm);
      OP_J:    word = {OPC_J, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader: packs instruction descriptors and writes them to
// consecutive instruction-memory words, holding the CPU in reset until done.
// Optional feature: define LOADER_CHECKSUM_EN for a running XOR of written words.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err_illegal,
  output logic [ADDR_W:0]   count,
  output logic              cpu_hold,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              accept;
  logic [31:0]       word;
  logic              illegal;

  instr_pack u_pack (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .target  (in_target),
    .word    (word),
    .illegal (illegal)
  );

  assign in_ready = (state == S_LOAD) && !start;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == S_LOAD);
  assign done     = (state == S_DONE);
  assign full     = (state == S_FULL);
  assign cpu_hold = (state != S_DONE);

  // Next state and next write address; start overrides any beat.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    if (start) begin
      state_nxt = S_LOAD;
      addr_nxt  = BASE;
    end else if (accept) begin
      if (in_last)                 state_nxt = S_DONE;
      else if (addr == ADDR_MAX)   state_nxt = S_FULL;
      else                         addr_nxt  = addr + 1'b1;
    end
  end

  // State and address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      addr  <= BASE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
      addr  <= addr_nxt;
    end
  end

  // Registered write port, word counter and sticky illegal flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the write-data register is control-visible output, so it is reset like the rest.
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      err_illegal <= 1'b0;
      count       <= '0;
    end else begin
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= addr;
        imem_wdata <= word;
      end
      if (start) begin
        err_illegal <= 1'b0;
        count       <= '0;
      end else if (accept) begin
        count <= count + 1'b1;
        if (illegal) err_illegal <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] cks;

  // Running XOR of every written word since the last start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cks <= '0;
    else if (start)  cks <= '0;
    else if (accept) cks <= cks ^ word;
  end

  assign checksum = cks;
`else
  assign checksum = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: directed descriptor vectors,
// a behavioural reference model compared every cycle, and literal pins.
module tb_imem_program_loader;

  localparam int AW = 2;
  localparam int MAX_ADDR = (1 << AW) - 1;
  localparam int P_IDLE = 0, P_LOAD = 1, P_DONE = 2, P_FULL = 3;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_last;
  logic [4:0]    in_op, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_ready, imem_we, busy, done, full, err_illegal, cpu_hold;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata, checksum;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_err = 0;

  imem_program_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .full(full), .err_illegal(err_illegal),
    .count(count), .cpu_hold(cpu_hold), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoder written from the MIPS field tables.
  function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                           input int rd, input int sh, input int imm,
                                           input int tgt, output bit bad);
    int funct, opc;
    bad = 0;
    if (op <= 7) begin
      case (op)
        0: funct = 32; 1: funct = 34; 2: funct = 36; 3: funct = 37;
        4: funct = 42; 5: funct = 39; 6: funct = 0;  default: funct = 2;
      endcase
      if (op >= 6) rs = 0; else sh = 0;
      return 32'((rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | funct);
    end else if (op <= 15) begin
      case (op)
        8: opc = 35; 9: opc = 43; 10: opc = 8; 11: opc = 12;
        12: opc = 13; 13: opc = 10; 14: opc = 4; default: opc = 5;
      endcase
      return 32'((opc << 26) | (rs << 21) | (rt << 16) | (imm & 16'hFFFF));
    end else if (op == 16) begin
      return 32'((2 << 26) | (tgt & 26'h3FF_FFFF));
    end
    bad = 1;
    return 32'h0;
  endfunction

  // Model state
  int          m_phase;
  int          m_next;
  int          m_count;
  bit          m_err;
  bit          m_we;
  int          m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_cks;

  always @(posedge clk or posedge rst) begin
    bit bad;
    logic [31:0] w;
    if (rst) begin
      m_phase = P_IDLE; m_next = 0; m_count = 0; m_err = 0;
      m_we = 0; m_addr = 0; m_wdata = 0; m_cks = 0;
    end else begin
      m_we = 0;
      if (start) begin
        m_phase = P_LOAD; m_next = 0; m_count = 0; m_err = 0; m_cks = 0;
      end else if (m_phase == P_LOAD && in_valid) begin
        w = ref_word(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, bad);
        m_we = 1; m_addr = m_next; m_wdata = w;
        m_count++; m_cks ^= w;
        if (bad) m_err = 1;
        if (in_last) m_phase = P_DONE;
        else if (m_next == MAX_ADDR) m_phase = P_FULL;
        else m_next++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(m_phase == P_LOAD && !start));
    check("imem_we", 32'(imem_we), 32'(m_we));
    if (m_we) begin
      check("imem_addr", 32'(imem_addr), 32'(m_addr));
      check("imem_wdata", imem_wdata, m_wdata);
    end
    check("busy", 32'(busy), 32'(m_phase == P_LOAD));
    check("done", 32'(done), 32'(m_phase == P_DONE));
    check("full", 32'(full), 32'(m_phase == P_FULL));
    check("cpu_hold", 32'(cpu_hold), 32'(m_phase != P_DONE));
    check("err_illegal", 32'(err_illegal), 32'(m_err));
    check("count", 32'(count), 32'(m_count));
`ifdef LOADER_CHECKSUM_EN
    check("checksum", checksum, m_cks);
`else
    check("checksum", checksum, 32'h0);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int op, input int rs, input int rt, input int rd,
                      input int sh, input int imm, input int tgt, input bit last);
    in_valid = 1'b1; in_op = 5'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_shamt = 5'(sh); in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_last = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_imm = '0; in_target = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    idle_in();
    step(); step();
    // Reset values
    check("rst_we", 32'(imem_we), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'h1);
    check("rst_count", 32'(count), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    step();

    // Single ADD, last
    do_start();
    beat(0, 1, 2, 3, 0, 0, 0, 1);
    step();
    idle_in();
    check("add_we", 32'(imem_we), 32'h1);
    check("add_addr", 32'(imem_addr), 32'h0);
    check("add_wdata", imem_wdata, 32'h0022_1820);
    check("add_done", 32'(done), 32'h1);
    check("add_hold", 32'(cpu_hold), 32'h0);
    check("add_count", 32'(count), 32'h1);
    step();

    // Back-to-back LW, SLL (rs ignored), J
    do_start();
    beat(8, 0, 8, 0, 0, 4, 0, 0);
    step();
    check("lw_wdata", imem_wdata, 32'h8C08_0004);
    check("lw_addr", 32'(imem_addr), 32'h0);
    beat(6, 7, 1, 2, 4, 0, 0, 0);
    step();
    check("sll_wdata", imem_wdata, 32'h0001_1100);
    check("sll_addr", 32'(imem_addr), 32'h1);
`ifdef LOADER_CHECKSUM_EN
    check("cks_two", checksum, 32'h8C09_1104);
`endif
    beat(16, 0, 0, 0, 0, 0, 'h10, 1);
    step();
    idle_in();
    check("j_wdata", imem_wdata, 32'h0800_0010);
    check("j_addr", 32'(imem_addr), 32'h2);
    check("j_done", 32'(done), 32'h1);
    step();

    // Memory exhaustion: four non-last beats fill 4 words
    do_start();
    for (int i = 0; i < 4; i++) begin
      beat(i, i + 1, i + 2, i + 3, 0, 0, 0, 0);
      step();
    end
    check("full_addr", 32'(imem_addr), 32'h3);
    check("full_flag", 32'(full), 32'h1);
    check("full_ready", 32'(in_ready), 32'h0);
    step();
    check("full_nowrite", 32'(imem_we), 32'h0);
    idle_in();
    step();

    // Illegal op then ORI last
    do_start();
    beat(20, 1, 2, 3, 4, 5, 6, 0);
    step();
    check("ill_wdata", imem_wdata, 32'h0);
    check("ill_err", 32'(err_illegal), 32'h1);
    check("ill_busy", 32'(busy), 32'h1);
    beat(12, 3, 4, 0, 0, 'h00FF, 0, 1);
    step();
    idle_in();
    check("ori_wdata", imem_wdata, 32'h3464_00FF);
    check("ori_addr", 32'(imem_addr), 32'h1);
    check("ori_err_sticky", 32'(err_illegal), 32'h1);
    step();

    // Reset the cycle after acceptance drops the write
    do_start();
    beat(1, 4, 5, 6, 0, 0, 0, 0);
    step();
    idle_in();
    rst = 1'b1;
    #1;
    check("rstmid_we", 32'(imem_we), 32'h0);
    check("rstmid_count", 32'(count), 32'h0);
    check("rstmid_busy", 32'(busy), 32'h0);
    check("rstmid_hold", 32'(cpu_hold), 32'h1);
    step();
    rst = 1'b0;
    step();

    // Start while a write is pending and coincident with a beat
    do_start();
    beat(3, 1, 1, 1, 0, 0, 0, 0);
    step();
    check("pend_we", 32'(imem_we), 32'h1);
    check("pend_addr", 32'(imem_addr), 32'h0);
    start = 1'b1;
    beat(5, 2, 3, 4, 0, 0, 0, 1);
    step();
    start = 1'b0;
    check("coinc_we", 32'(imem_we), 32'h0);
    check("coinc_count", 32'(count), 32'h0);
    step();
    idle_in();
    check("restart_addr", 32'(imem_addr), 32'h0);
    check("restart_wdata", imem_wdata, 32'h0043_2027);
    check("restart_count", 32'(count), 32'h1);
    check("restart_done", 32'(done), 32'h1);
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
